// File: rtl/mmio_register_bank.sv
// rtl/mmio_register_bank.sv - mirrored MMIO register bank with write toggle, sticky status and auto-increment pointer
// Optional feature macro: MMIO_READ_BUFFER_EN (data-port reads return a one-read-late buffer)
module mmio_register_bank #(
   parameter int                DATA_W     = 8,
   parameter int                ADDR_W     = 16,
   parameter int                NUM_REGS   = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h2000,
   parameter logic [ADDR_W-1:0] SPAN       = 16'h2000,
   parameter int                STATUS_IDX = 2,
   parameter int                PTR_IDX    = 3,
   parameter int                DATA_IDX   = 4,
   parameter int                TOG_A_IDX  = 5,
   parameter int                TOG_B_IDX  = 6,
   parameter logic [DATA_W-1:0] CLR_MASK   = 8'hE0,
   parameter int                CLR_DELAY  = 6,
   parameter int                STEP_SMALL = 1,
   parameter int                STEP_LARGE = 4
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic [ADDR_W-1:0]            Addr,
   input  logic                         Wr,
   input  logic                         Rd,
   input  logic [DATA_W-1:0]            Wdata,
   output logic [DATA_W-1:0]            Rdata,
   input  logic [DATA_W-1:0]            Status_set,
   input  logic                         Ext_we,
   input  logic [DATA_W-1:0]            Ext_wdata,
   input  logic                         Ptr_clr,
   input  logic                         Ptr_step_large,
   input  logic [DATA_W-1:0]            Mem_rdata,
   output logic [NUM_REGS*DATA_W-1:0]   Reg_q,
   output logic [NUM_REGS-1:0]          Wr_pulse,
   output logic [NUM_REGS-1:0]          Rd_pulse,
   output logic [DATA_W-1:0]            Ptr,
   output logic                         Toggle,
   output logic                         Collision
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int CNT_W = 4;

   // Window bounds carry one extra bit so BASE_ADDR+SPAN cannot overflow
   localparam logic [ADDR_W:0]   WIN_LO = {1'b0, BASE_ADDR};
   localparam logic [ADDR_W:0]   WIN_HI = WIN_LO + {1'b0, SPAN};

   localparam logic [IDX_W-1:0]  STATUS_SEL = IDX_W'(STATUS_IDX);
   localparam logic [IDX_W-1:0]  PTR_SEL    = IDX_W'(PTR_IDX);
   localparam logic [IDX_W-1:0]  DATA_SEL   = IDX_W'(DATA_IDX);
   localparam logic [IDX_W-1:0]  TOG_A_SEL  = IDX_W'(TOG_A_IDX);
   localparam logic [IDX_W-1:0]  TOG_B_SEL  = IDX_W'(TOG_B_IDX);

   localparam logic [DATA_W-1:0]   STEP_S   = DATA_W'(STEP_SMALL);
   localparam logic [DATA_W-1:0]   STEP_L   = DATA_W'(STEP_LARGE);
   localparam logic [CNT_W-1:0]    CLR_LOAD = CNT_W'(CLR_DELAY);
   localparam logic [NUM_REGS-1:0] ONEHOT0  = NUM_REGS'(1);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic              toggle_q, toggle_d;
   logic              collision_q, collision_d;

   logic [ADDR_W:0]   addr_ext;
   logic [IDX_W-1:0]  idx;
   logic              hit;
   logic              wr_hit;
   logic              rd_hit;
   logic              status_rd;
   logic              cpu_wr_ptr;
   logic              cpu_wr_data;
   logic              data_port_wr;
   logic              tog_flip;
   logic              clr_fire;
   logic [DATA_W-1:0] clr_bits;
   logic [DATA_W-1:0] ptr_step;
   logic [DATA_W-1:0] data_rd_val;

   // Address decode: the bank repeats every NUM_REGS addresses across the window
   assign addr_ext = {1'b0, Addr};
   assign hit      = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
   assign idx      = Addr[IDX_W-1:0];
   assign wr_hit   = Wr & hit;
   assign rd_hit   = Rd & hit;

   assign status_rd    = rd_hit && (idx == STATUS_SEL);
   assign cpu_wr_ptr   = wr_hit && (idx == PTR_SEL);
   assign cpu_wr_data  = wr_hit && (idx == DATA_SEL);
   assign data_port_wr = Ext_we | cpu_wr_data;
   assign tog_flip     = wr_hit && ((idx == TOG_A_SEL) || (idx == TOG_B_SEL));

   // The counter counts down from CLR_DELAY; the clear is applied on the edge
   // that takes it from 1 to 0, which is CLR_DELAY+1 edges after the read cycle.
   assign clr_fire = (clr_cnt_q == CNT_W'(1));
   assign clr_bits = clr_fire ? CLR_MASK : '0;
   assign ptr_step = Ptr_step_large ? STEP_L : STEP_S;

   assign Wr_pulse = wr_hit ? (ONEHOT0 << idx) : '0;
   assign Rd_pulse = rd_hit ? (ONEHOT0 << idx) : '0;

`ifdef MMIO_READ_BUFFER_EN
   logic [DATA_W-1:0] rbuf_q, rbuf_d;

   // Capture memory data on each data-port read so the next read returns it
   always_comb begin
      rbuf_d = rbuf_q;
      if (rd_hit && (idx == DATA_SEL)) begin
         rbuf_d = Mem_rdata;
      end
   end

   // Read buffer register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rbuf_q <= '0;
      end else begin
         rbuf_q <= rbuf_d;
      end
   end

   assign data_rd_val = rbuf_q;
`else
   assign data_rd_val = Mem_rdata;
`endif

   // Read mux: zero unless a read hits the window
   always_comb begin
      Rdata = '0;
      if (rd_hit) begin
         if (idx == DATA_SEL) begin
            Rdata = data_rd_val;
         end else begin
            Rdata = regs_q[idx];
         end
      end
   end

   // Next register contents, with status/pointer/data-port overrides applied last
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_hit && (idx == IDX_W'(i))) begin
            regs_d[i] = Wdata;
         end
      end

      // Status is CPU read-only; a set in the clearing cycle wins over the clear
      regs_d[STATUS_IDX] = (regs_q[STATUS_IDX] & ~clr_bits) | Status_set;

      if (Ptr_clr) begin
         regs_d[PTR_IDX] = '0;
      end else if (cpu_wr_ptr) begin
         regs_d[PTR_IDX] = Wdata;
      end else if (data_port_wr) begin
         regs_d[PTR_IDX] = regs_q[PTR_IDX] + ptr_step;
      end else begin
         regs_d[PTR_IDX] = regs_q[PTR_IDX];
      end

      // DMA owns the data port when both sides write in the same cycle
      if (Ext_we) begin
         regs_d[DATA_IDX] = Ext_wdata;
      end else if (cpu_wr_data) begin
         regs_d[DATA_IDX] = Wdata;
      end else begin
         regs_d[DATA_IDX] = regs_q[DATA_IDX];
      end
   end

   // Delayed clear counter: a read while armed does not restart it
   always_comb begin
      clr_cnt_d = clr_cnt_q;
      if (clr_cnt_q != '0) begin
         clr_cnt_d = clr_cnt_q - CNT_W'(1);
      end else if (status_rd) begin
         clr_cnt_d = CLR_LOAD;
      end
   end

   // Toggle and collision next state; a status read beats a flipping write
   always_comb begin
      toggle_d = toggle_q;
      if (status_rd) begin
         toggle_d = 1'b0;
      end else if (tog_flip) begin
         toggle_d = ~toggle_q;
      end
      collision_d = Ext_we & cpu_wr_data;
   end

   // Register bank state
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Control state; reset also aborts any pending status clear
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         clr_cnt_q   <= '0;
         toggle_q    <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         clr_cnt_q   <= clr_cnt_d;
         toggle_q    <= toggle_d;
         collision_q <= collision_d;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign Reg_q[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign Ptr       = regs_q[PTR_IDX];
   assign Toggle    = toggle_q;
   assign Collision = collision_q;

endmodule

// File: tb/tb_mmio_register_bank.sv
// tb/tb_mmio_register_bank.sv - directed and randomized self-checking bench for mmio_register_bank
module tb_mmio_register_bank;

   localparam int CLR_D = 6;
`ifdef MMIO_READ_BUFFER_EN
   localparam int BUF_EN = 1;
`else
   localparam int BUF_EN = 0;
`endif

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] Addr;
   logic        Wr;
   logic        Rd;
   logic [7:0]  Wdata;
   logic [7:0]  Rdata;
   logic [7:0]  Status_set;
   logic        Ext_we;
   logic [7:0]  Ext_wdata;
   logic        Ptr_clr;
   logic        Ptr_step_large;
   logic [7:0]  Mem_rdata;
   logic [63:0] Reg_q;
   logic [7:0]  Wr_pulse;
   logic [7:0]  Rd_pulse;
   logic [7:0]  Ptr;
   logic        Toggle;
   logic        Collision;

   always #5 Clk = ~Clk;

   mmio_register_bank dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .Addr           (Addr),
      .Wr             (Wr),
      .Rd             (Rd),
      .Wdata          (Wdata),
      .Rdata          (Rdata),
      .Status_set     (Status_set),
      .Ext_we         (Ext_we),
      .Ext_wdata      (Ext_wdata),
      .Ptr_clr        (Ptr_clr),
      .Ptr_step_large (Ptr_step_large),
      .Mem_rdata      (Mem_rdata),
      .Reg_q          (Reg_q),
      .Wr_pulse       (Wr_pulse),
      .Rd_pulse       (Rd_pulse),
      .Ptr            (Ptr),
      .Toggle         (Toggle),
      .Collision      (Collision)
   );

   int total  = 0;
   int passed = 0;
   int cyc    = 0;

   // Reference model: register values, toggle, collision, buffer and the
   // absolute edge number at which the pending status clear lands
   int m_reg [8];
   int m_tog;
   int m_coll;
   int m_buf;
   int clr_at;
   logic [7:0] last_rdata;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      Addr = 16'h0000; Wr = 1'b0; Rd = 1'b0; Wdata = 8'h00;
      Status_set = 8'h00; Ext_we = 1'b0; Ext_wdata = 8'h00;
      Ptr_clr = 1'b0; Ptr_step_large = 1'b0; Mem_rdata = 8'h00;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 0;
      m_tog = 0; m_coll = 0; m_buf = 0; clr_at = -1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 1'b0;
      model_reset();
   endtask

   // One clock: check combinational outputs mid-cycle, then state after the edge
   task automatic tick();
      int a, hit, idx, wr_h, rd_h, stat_rd, step, exp_rd;
      int nreg [8];
      int ntog, ncoll, nbuf;
      logic [63:0] exp_q;
      @(negedge Clk);
      a     = int'(Addr);
      hit   = (a >= 'h2000 && a < 'h4000) ? 1 : 0;
      idx   = a % 8;
      wr_h  = (Wr && hit) ? 1 : 0;
      rd_h  = (Rd && hit) ? 1 : 0;
      exp_rd = 0;
      if (rd_h) exp_rd = (idx == 4) ? (BUF_EN ? m_buf : int'(Mem_rdata)) : m_reg[idx];
      last_rdata = Rdata;
      check("rdata", Rdata, exp_rd);
      check("wr_pulse", Wr_pulse, wr_h ? (1 << idx) : 0);
      check("rd_pulse", Rd_pulse, rd_h ? (1 << idx) : 0);

      for (int i = 0; i < 8; i++) nreg[i] = m_reg[i];
      if (wr_h && idx != 2 && idx != 3 && idx != 4) nreg[idx] = int'(Wdata);
      if (clr_at == cyc + 1) nreg[2] = (m_reg[2] % 32) | int'(Status_set);
      else nreg[2] = m_reg[2] | int'(Status_set);
      stat_rd = (rd_h && idx == 2) ? 1 : 0;
      if (stat_rd && clr_at < cyc + 1) clr_at = cyc + 1 + CLR_D;
      ntog = stat_rd ? 0 : ((wr_h && (idx == 5 || idx == 6)) ? 1 - m_tog : m_tog);
      step = Ptr_step_large ? 4 : 1;
      if (Ptr_clr) nreg[3] = 0;
      else if (wr_h && idx == 3) nreg[3] = int'(Wdata);
      else if (Ext_we || (wr_h && idx == 4)) nreg[3] = (m_reg[3] + step) % 256;
      if (Ext_we) nreg[4] = int'(Ext_wdata);
      else if (wr_h && idx == 4) nreg[4] = int'(Wdata);
      ncoll = (Ext_we && wr_h && idx == 4) ? 1 : 0;
      nbuf  = (rd_h && idx == 4) ? int'(Mem_rdata) : m_buf;

      @(posedge Clk);
      #1;
      cyc++;
      for (int i = 0; i < 8; i++) m_reg[i] = nreg[i];
      m_tog = ntog; m_coll = ncoll; m_buf = nbuf;
      for (int i = 0; i < 8; i++) exp_q[i*8 +: 8] = 8'(m_reg[i]);
      check("reg_q", Reg_q, exp_q);
      check("toggle", Toggle, m_tog);
      check("collision", Collision, m_coll);
      check("ptr", Ptr, m_reg[3]);
   endtask

   initial begin
      idle();
      do_reset();
      check("rst_regq", Reg_q, 64'h0);
      check("rst_toggle", Toggle, 1'b0);
      check("rst_collision", Collision, 1'b0);

      // Read every index straight after reset
      for (int i = 0; i < 8; i++) begin
         idle(); Addr = 16'h2000 + 16'(i); Rd = 1'b1;
         tick();
         check("rst_read", last_rdata, 8'h00);
      end

      // Mirrored write to index 5 flips the toggle
      idle(); Addr = 16'h200D; Wr = 1'b1; Wdata = 8'h5A;
      tick();
      check("mirror_w5", Reg_q[47:40], 8'h5A);
      check("tog_set", Toggle, 1'b1);

      // Sticky status, delayed clear, re-read ignored while armed
      idle(); Status_set = 8'h80;
      tick();
      idle(); Addr = 16'h2002; Rd = 1'b1;
      tick();
      check("stat_rd", last_rdata, 8'h80);
      check("tog_clr", Toggle, 1'b0);
      check("stat_e1", Reg_q[23], 1'b1);
      for (int k = 2; k <= 9; k++) begin
         idle();
         if (k == 4) begin Addr = 16'h2002; Rd = 1'b1; end
         tick();
         check("stat_clr_timing", Reg_q[23], (k < 7) ? 1'b1 : 1'b0);
      end

      // Pointer wrap with the large step
      idle(); Addr = 16'h2003; Wr = 1'b1; Wdata = 8'hFE;
      tick();
      check("ptr_load", Ptr, 8'hFE);
      idle(); Addr = 16'h2004; Wr = 1'b1; Wdata = 8'h01; Ptr_step_large = 1'b1;
      tick();
      check("ptr_wrap", Ptr, 8'h02);
      idle(); Addr = 16'h2004; Wr = 1'b1; Wdata = 8'h02; Ptr_step_large = 1'b1;
      tick();
      check("ptr_inc", Ptr, 8'h06);

      // DMA and CPU data-port write collide
      idle(); Addr = 16'h2004; Wr = 1'b1; Wdata = 8'h44; Ext_we = 1'b1; Ext_wdata = 8'h33;
      Ptr_step_large = 1'b1;
      tick();
      check("coll_data", Reg_q[39:32], 8'h33);
      check("coll_ptr", Ptr, 8'h0A);
      check("coll_pulse", Collision, 1'b1);
      idle();
      tick();
      check("coll_once", Collision, 1'b0);

      // Misses produce nothing
      idle(); Addr = 16'h4000; Wr = 1'b1; Wdata = 8'hFF;
      tick();
      idle(); Addr = 16'h1FFF; Rd = 1'b1;
      tick();
      check("miss_rd", last_rdata, 8'h00);

      // Data-port reads, direct or through the buffer
      idle(); Addr = 16'h2004; Rd = 1'b1; Mem_rdata = 8'h11;
      tick();
      check("dport_rd1", last_rdata, BUF_EN ? 8'h00 : 8'h11);
      idle(); Addr = 16'h2004; Rd = 1'b1; Mem_rdata = 8'h22;
      tick();
      check("dport_rd2", last_rdata, BUF_EN ? 8'h11 : 8'h22);

      // Reset while the clear is pending cancels it
      idle(); Addr = 16'h2002; Rd = 1'b1;
      tick();
      idle();
      tick();
      tick();
      do_reset();
      idle(); Status_set = 8'h80;
      tick();
      idle();
      repeat (10) tick();
      check("rst_abort_clear", Reg_q[23], 1'b1);
      check("rst_ptr", Ptr, 8'h00);

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 400; n++) begin
         int op, r;
         idle();
         op = $urandom_range(0, 9);
         r  = $urandom_range(0, 15);
         if (r == 0)      Addr = 16'($urandom);
         else if (r == 1) Addr = 16'h1FFF;
         else if (r == 2) Addr = 16'h4000;
         else             Addr = 16'h2000 + 16'($urandom_range(0, 'h1FFF));
         if (op < 4) begin
            Wr = 1'b1; Wdata = 8'($urandom);
         end else if (op < 7) begin
            Rd = 1'b1;
         end
         Status_set     = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
         Ext_we         = ($urandom_range(0, 5) == 0);
         Ext_wdata      = 8'($urandom);
         Ptr_clr        = ($urandom_range(0, 19) == 0);
         Ptr_step_large = 1'($urandom_range(0, 1));
         Mem_rdata      = 8'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mmio_register_bank.md
# mmio_register_bank

Parametrised CPU-facing memory-mapped register bank for the PPU/APU I/O window. It decodes a mirrored address range into `NUM_REGS` registers and provides three side effects in hardware:
- a shared write-toggle latch;
- sticky status bits with delayed clear-on-read;
- an auto-incrementing pointer register driven by CPU or DMA writes to a data port.

It sits between the CPU bus and the PPU/OAM/DMA logic. It replaces fixed-function decode with one reusable block per peripheral window.

## Interface
Parameters:
- `DATA_W`, 8, register width.
- `ADDR_W`, 16, CPU address width.
- `NUM_REGS`, 8, register count, power of two ≥ 4; index = `Addr[$clog2(NUM_REGS)-1:0]`.
- `BASE_ADDR`, 16'h2000, first decoded address.
- `SPAN`, 16'h2000, decoded window size (multiple of `NUM_REGS`); the bank is mirrored across it.
- `STATUS_IDX`, 2, index of the status register.
- `PTR_IDX`, 3, index of the pointer register.
- `DATA_IDX`, 4, index of the data port.
- `TOG_A_IDX`, 5, first register index that flips the toggle.
- `TOG_B_IDX`, 6, second register index that flips the toggle.
- `CLR_MASK`, 8'hE0, status bits cleared by a status read.
- `CLR_DELAY`, 6, cycles from a status read to the clear, range 1..15.
- `STEP_SMALL`, 1, small pointer increment.
- `STEP_LARGE`, 4, large pointer increment.

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high.
- `Addr`  in  ADDR_W  CPU address.
- `Wr`  in  1  CPU write strobe, one cycle per access.
- `Rd`  in  1  CPU read strobe, one cycle per access.
- `Wdata`  in  DATA_W  CPU write data.
- `Rdata`  out  DATA_W  read data. Combinational; 0 when `Rd` is low or the address misses the window.
- `Status_set`  in  DATA_W  per-bit hardware set of status bits.
- `Ext_we`  in  1  external (DMA) write to the data port.
- `Ext_wdata`  in  DATA_W  DMA write data.
- `Ptr_clr`  in  1  synchronous clear of the pointer register.
- `Ptr_step_large`  in  1  selects `STEP_LARGE` (1) or `STEP_SMALL` (0).
- `Mem_rdata`  in  DATA_W  downstream memory data at address `Ptr`.
- `Reg_q`  out  NUM_REGS*DATA_W  all register contents; register i occupies bits [i*DATA_W +: DATA_W].
- `Wr_pulse`  out  NUM_REGS  one-hot decoded write strobe, same cycle as `Wr`.
- `Rd_pulse`  out  NUM_REGS  one-hot decoded read strobe, same cycle as `Rd`.
- `Ptr`  out  DATA_W  pointer register; equals register `PTR_IDX`.
- `Toggle`  out  1  write-toggle latch.
- `Collision`  out  1  registered pulse; CPU data-port write dropped.

## Operation
- **Hit:** `BASE_ADDR ≤ Addr < BASE_ADDR+SPAN`. On a miss the block produces no pulses, no state change, and `Rdata`=0.
- **Write** (`Wr` and hit): register[idx] ← `Wdata` at the next edge.
  - The status register is read-only from the CPU. A write to it still raises `Wr_pulse` but does not change the register.
- **Status:** each bit is set when its `Status_set` bit is high, and stays set (sticky).
  - A status read arms the clear counter, which loads `CLR_DELAY`.
  - When the counter reaches 0, bits in `CLR_MASK` clear for one cycle. A `Status_set` bit high in that cycle wins over the clear.
  - A further status read while the counter is armed is ignored; it does not restart the counter.
- **Toggle:** flips on each write to `TOG_A_IDX` or `TOG_B_IDX`.
  - Clears at the edge after any status read.
  - If a clearing read and a flipping write occur in the same cycle, the clear wins.
- **Pointer** priority, highest first:
  1. `Ptr_clr`.
  2. CPU write to `PTR_IDX`.
  3. Increment by the selected step on a data-port write (CPU or `Ext_we`).
  
  The pointer wraps modulo 2^DATA_W; for example 8'hFE + 4 = 8'h02.
- **Data port:** `Ext_we` beats a CPU write to `DATA_IDX` in the same cycle.
  - The register takes `Ext_wdata` and the pointer increments once.
  - The CPU write is dropped and `Collision` pulses on the following cycle.
- **Read of `DATA_IDX`:** returns `Mem_rdata`, or the read buffer when the buffer feature is enabled (see Configuration). All other reads return the register value.

## Timing
- Reset values: all registers 0, `Toggle` 0, counter idle, `Collision` 0, buffer 0, `Rdata` 0.
- Register and pointer updates take effect 1 cycle after the strobe. `Rdata`, `Wr_pulse` and `Rd_pulse` have 0-cycle latency.
- Status clear lands `CLR_DELAY`+1 edges after the read cycle.
- Reset mid-count aborts the pending clear; no clear occurs after reset is released.

## Configuration
- `MMIO_READ_BUFFER_EN` defined:
  - A read of `DATA_IDX` returns the buffer register.
  - The buffer loads `Mem_rdata` at the edge 1 cycle after the read, giving a one-read-late data stream.
  - A CPU write to `PTR_IDX` does not touch the buffer.
- `MMIO_READ_BUFFER_EN` undefined: the buffer is absent and a read of `DATA_IDX` returns `Mem_rdata` directly.

## Test plan
- Reset, then read every index → `Rdata`=0, `Toggle`=0. Write 8'h5A to 16'h200D (mirror of index 5) → `Reg_q` index 5 = 8'h5A, `Toggle`=1.
- `Status_set`=8'h80 for 1 cycle, then status read → `Rdata`=8'h80, `Toggle`=0 next cycle, bit 7 clears exactly 7 edges after the read. A second read at +3 cycles does not delay the clear.
- Write `PTR_IDX`=8'hFE, `Ptr_step_large`=1, two CPU data writes → `Ptr`=8'h02, then 8'h06.
- `Ext_we` with 8'h33 and a CPU data write of 8'h44 in the same cycle → data register = 8'h33, `Ptr` +1 step, `Collision`=1 on the next cycle only.
- With `MMIO_READ_BUFFER_EN`, `Mem_rdata` = 8'h11 then 8'h22 on two successive reads → `Rdata` = 8'h00, then 8'h11.
- Assert `Reset` 2 cycles after a status read → no clear pulse after release; `Ptr`=0.
